// File: rtl/id_stage_param.sv
// Instruction decode stage for a classic 5-stage MIPS-style pipeline.
// Holds the register file, resolves operand forwarding, detects load-use
// hazards, resolves branches and jumps, and drives the ID/EX pipeline register.
module id_stage_param #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned CNTW = 16,
  localparam int unsigned AW  = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [AW-1:0]   ex_dst,
  input  logic [XLEN-1:0] ex_result,
  output logic            stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs_data,
  output logic [XLEN-1:0] out_rt_data,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rs,
  output logic [AW-1:0]   out_rt,
  output logic [AW-1:0]   out_rd,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] redirect_cnt
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] FunctJr   = 6'h08;

  logic [XLEN-1:0] r_rf [NREG];

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_out_rs_data;
  logic [XLEN-1:0] r_out_rt_data;
  logic [XLEN-1:0] r_out_imm;
  logic [AW-1:0]   r_out_rs;
  logic [AW-1:0]   r_out_rt;
  logic [AW-1:0]   r_out_rd;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_redirect_cnt;

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [AW-1:0]   w_rs;
  logic [AW-1:0]   w_rt;
  logic [AW-1:0]   w_rd;
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_br_tgt;
  logic [XLEN-1:0] w_j_tgt;
  logic            w_stall;
  logic            w_redirect;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_op    = in_inst[31:26];
  assign w_funct = in_inst[5:0];
  assign w_rs    = AW'(in_inst[25:21]);
  assign w_rt    = AW'(in_inst[20:16]);
  assign w_rd    = AW'(in_inst[15:11]);

  // Operand priority: r0, then EX ALU result (loads are not ready yet),
  // then the value being written back this cycle, then the register file.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_ld,
    input logic [AW-1:0]   ex_d,
    input logic [XLEN-1:0] ex_r,
    input logic            wb_en,
    input logic [AW-1:0]   wb_a,
    input logic [XLEN-1:0] wb_d
  );
    if (addr == '0)                 return '0;
    else if (ex_d == addr && !ex_ld) return ex_r;
    else if (wb_en && wb_a == addr)  return wb_d;
    else                             return rf_val;
  endfunction

  assign w_rs_data = fwd_sel(w_rs, r_rf[w_rs], ex_mem_read, ex_dst, ex_result,
                             wb_we, wb_addr, wb_data);
  assign w_rt_data = fwd_sel(w_rt, r_rf[w_rt], ex_mem_read, ex_dst, ex_result,
                             wb_we, wb_addr, wb_data);

  // Load-use hazard: the loaded value is not available until after MEM.
  assign w_stall = in_valid && ex_mem_read && (ex_dst != '0) &&
                   ((ex_dst == w_rs) || (ex_dst == w_rt));

  // Logical immediates zero-extend; everything else sign-extends.
  always_comb begin
    if (w_op == OpAndi || w_op == OpOri || w_op == OpXori) begin
      w_imm = XLEN'(in_inst[15:0]);
    end else begin
      w_imm = {{(XLEN-16){in_inst[15]}}, in_inst[15:0]};
    end
  end

  assign w_br_tgt = in_pc + (w_imm << 2);
  // Keep the upper PC bits above the 28-bit jump region.
  assign w_j_tgt  = (in_pc & ~XLEN'(32'h0FFF_FFFF)) | XLEN'({in_inst[25:0], 2'b00});

  // Control-transfer resolution; suppressed while stalled.
  always_comb begin
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    if (in_valid && !w_stall) begin
      case (w_op)
        OpBeq: begin
          if (w_rs_data == w_rt_data) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_br_tgt;
          end
        end
        OpBne: begin
          if (w_rs_data != w_rt_data) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_br_tgt;
          end
        end
        OpJ: begin
          w_redirect    = 1'b1;
          w_redirect_pc = w_j_tgt;
        end
        OpSpecial: begin
          if (w_funct == FunctJr) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_rs_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file write; r0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  // ID/EX register: a stall or an invalid slot inserts an all-zero bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || w_stall || !in_valid) begin
      r_out_valid   <= 1'b0;
      r_out_pc      <= '0;
      r_out_rs_data <= '0;
      r_out_rt_data <= '0;
      r_out_imm     <= '0;
      r_out_rs      <= '0;
      r_out_rt      <= '0;
      r_out_rd      <= '0;
    end else begin
      r_out_valid   <= 1'b1;
      r_out_pc      <= in_pc;
      r_out_rs_data <= w_rs_data;
      r_out_rt_data <= w_rt_data;
      r_out_imm     <= w_imm;
      r_out_rs      <= w_rs;
      r_out_rt      <= w_rt;
      r_out_rd      <= w_rd;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      if (w_stall && r_stall_cnt != '1)       r_stall_cnt    <= r_stall_cnt + 1'b1;
      if (w_redirect && r_redirect_cnt != '1) r_redirect_cnt <= r_redirect_cnt + 1'b1;
    end
  end

  assign stall        = w_stall;
  assign redirect     = w_redirect;
  assign redirect_pc  = w_redirect_pc;
  assign out_valid    = r_out_valid;
  assign out_pc       = r_out_pc;
  assign out_rs_data  = r_out_rs_data;
  assign out_rt_data  = r_out_rt_data;
  assign out_imm      = r_out_imm;
  assign out_rs       = r_out_rs;
  assign out_rt       = r_out_rt;
  assign out_rd       = r_out_rd;
  assign stall_cnt    = r_stall_cnt;
  assign redirect_cnt = r_redirect_cnt;

endmodule
